imem_multiport: RTL and testbench
=================================

Name: imem_multiport

Overview:
- Parameterised, byte-addressed instruction memory with NUM_READ independent registered read ports.
- Memory is filled by a streaming loader: a start command (base, word count) followed by a valid/ready data stream with auto-incrementing address.
- Adds per-port read valid/fault reporting and load range checking.
- Sits between the host/DMA loader and the core fetch stages.

Parameters:
- DEPTH, 256, number of BITWIDTH-bit words stored; must be a power of two ≥ 2.
- BITWIDTH, 32, width of addresses, instructions and load data.
- NUM_READ, 2, number of read ports, 1..8.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- read_en  in  NUM_READ  per-port read request.
- read_addr  in  NUM_READ*BITWIDTH  byte addresses; port i occupies bits [i*BITWIDTH +: BITWIDTH].
- read_instr  out  NUM_READ*BITWIDTH  registered read data, same packing as read_addr.
- read_valid  out  NUM_READ  read_instr/read_fault valid for port i this cycle.
- read_fault  out  NUM_READ  port i request was misaligned or out of range.
- load_start  in  1  start-load command pulse.
- load_base  in  BITWIDTH  byte base address of the load.
- load_count  in  BITWIDTH  number of words to load.
- load_data  in  BITWIDTH  stream data.
- load_valid  in  1  stream data valid.
- load_ready  out  1  loader accepts data.
- load_busy  out  1  loader in LOAD state.
- load_done  out  1  one-cycle pulse when a load completes.
- load_error  out  1  one-cycle pulse when a start command is rejected.

Behaviour:
- **Reset** (any cycle, including mid-load):
  - All memory words go to 0 and FSM goes to IDLE.
  - All outputs go to 0: read_instr, read_valid, read_fault, load_ready, load_busy, load_done, load_error.
- **Read, 1-cycle latency.** If read_en[i] is high at edge N, the port's outputs update at edge N+1 as follows:
  - read_valid[i]=1.
  - Word index = addr>>2.
  - Fault case: addr[1:0]≠0 or index ≥ DEPTH gives read_fault[i]=1 and read_instr[i]=0.
  - Normal case: read_fault[i]=0 and read_instr[i]=mem[index].
  - If read_en[i] is low, read_valid[i]=0 and read_fault[i]=0; read_instr[i] holds its previous value.
- Ports are fully independent; multiple ports may read the same address in the same cycle.
- **Read/write collision:** a read and a loader write to the same word in the same cycle return the OLD data (read-before-write).
- **FSM states:** IDLE, LOAD.
- **IDLE:**
  - load_ready=0, load_busy=0.
  - On load_start, the command is checked. If base[1:0]≠0, or (base>>2)+count > DEPTH (computed without overflow, BITWIDTH+1 bits), then:
    - load_error pulses on the next cycle.
    - FSM stays IDLE.
    - Memory is unchanged.
  - Otherwise, if count==0, load_done pulses on the next cycle and FSM stays IDLE.
  - Otherwise, the loader latches ptr=base>>2 and remaining=count, then moves to LOAD.
- **LOAD:**
  - load_busy=1, load_ready=1.
  - A beat is load_valid && load_ready. On each beat, mem[ptr]←load_data, ptr++, remaining--.
  - The beat with remaining==1 returns the FSM to IDLE. load_done pulses in the cycle after that beat.
  - Cycles with load_valid=0 are stalls: no write, no state change.
  - load_start while in LOAD is ignored: no error, no effect on the current load.
- ptr never wraps, because the range check at start guarantees ptr < DEPTH for every beat.
- load_done and load_error are never high in the same cycle.

Test Plan:
1. Reset then read: reset for 2 cycles, then read_en=all-ones, addr=0x0/0x4 → next cycle read_valid=all-ones, read_fault=0, read_instr=0 on all ports.
2. Load and readback: load_start base=0x10 count=3, stream 0xA1,0xA2,0xA3 with one load_valid=0 stall between beats 1 and 2 → writes land at words 4,5,6; load_done pulses exactly once, in the cycle after the third beat. Port0 addr 0x14 and port1 addr 0x18 return 0xA2 and 0xA3 one cycle after the request.
3. Faults: read addr 0x2 → read_fault=1, read_instr=0. Read addr DEPTH*4 → read_fault=1. Another port reading 0x0 in the same cycle → fault=0.
4. Load rejection:
   - base=0x3 → load_error pulse, load_busy stays 0, memory unchanged.
   - base=(DEPTH-2)*4 with count=3 → load_error.
   - Same base with count=2 → accepted and completes.
5. Collision and ignored start: during a load, read the word currently being written → old value (0) returned. Issue load_start mid-load → ignored; the original load completes with the original count.
6. Reset mid-load: after 1 of 4 beats, assert reset → load_busy=0, load_ready=0, word written by beat 1 reads back 0, and no load_done pulse is generated.

Source files
------------

// File: rtl/imem_multiport_if.sv
// Bus between the loader/fetch side (master) and the instruction memory (slave).
interface imem_multiport_if #(
    parameter int unsigned BITWIDTH = 32,
    parameter int unsigned NUM_READ = 2
);
    logic [NUM_READ-1:0]          read_en;
    logic [NUM_READ*BITWIDTH-1:0] read_addr;
    logic [NUM_READ*BITWIDTH-1:0] read_instr;
    logic [NUM_READ-1:0]          read_valid;
    logic [NUM_READ-1:0]          read_fault;
    logic                         load_start;
    logic [BITWIDTH-1:0]          load_base;
    logic [BITWIDTH-1:0]          load_count;
    logic [BITWIDTH-1:0]          load_data;
    logic                         load_valid;
    logic                         load_ready;
    logic                         load_busy;
    logic                         load_done;
    logic                         load_error;

    modport master (
        output read_en, read_addr, load_start, load_base, load_count, load_data, load_valid,
        input  read_instr, read_valid, read_fault, load_ready, load_busy, load_done, load_error
    );

    modport slave (
        input  read_en, read_addr, load_start, load_base, load_count, load_data, load_valid,
        output read_instr, read_valid, read_fault, load_ready, load_busy, load_done, load_error
    );
endinterface

// File: rtl/imem_multiport.sv
// Byte-addressed instruction memory with NUM_READ registered read ports and a
// streaming loader (start command + valid/ready data beats).
module imem_multiport #(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned BITWIDTH = 32,
    parameter int unsigned NUM_READ = 2
) (
    input logic             clock,
    input logic             reset,
    imem_multiport_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned EW = BITWIDTH + 1;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [BITWIDTH-1:0] remaining_q, remaining_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                write_en;
    logic [EW-1:0]       load_end;

    logic [BITWIDTH-1:0] mem [DEPTH];

    logic [BITWIDTH-1:0]          rd_word [NUM_READ];
    logic [NUM_READ-1:0]          rd_fault_c;
    logic [NUM_READ*BITWIDTH-1:0] instr_q;
    logic [NUM_READ-1:0]          valid_q;
    logic [NUM_READ-1:0]          fault_q;

    // Loader next-state; end word is computed one bit wider so huge counts cannot wrap
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        write_en    = 1'b0;
        load_end    = EW'(bus.load_base >> 2) + EW'(bus.load_count);
        case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    if ((bus.load_base[1:0] != 2'b00) || (load_end > EW'(DEPTH))) begin
                        error_d = 1'b1;
                    end else if (bus.load_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = LOAD;
                        ptr_d       = AW'(bus.load_base >> 2);
                        remaining_d = bus.load_count;
                    end
                end
            end
            LOAD: begin
                if (bus.load_valid) begin
                    write_en    = 1'b1;
                    ptr_d       = ptr_q + AW'(1);
                    remaining_d = remaining_q - BITWIDTH'(1);
                    if (remaining_q == BITWIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Storage; reads below sample the pre-edge contents, giving read-before-write
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_en) begin
            mem[ptr_q] <= bus.load_data;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_READ; p++) begin
            rd_word[p]    = bus.read_addr[p*BITWIDTH +: BITWIDTH] >> 2;
            rd_fault_c[p] = (bus.read_addr[p*BITWIDTH +: 2] != 2'b00) ||
                            (rd_word[p] >= BITWIDTH'(DEPTH));
        end
    end

    // Read ports; data holds when a port is not requested
    always_ff @(posedge clock) begin
        if (reset) begin
            instr_q <= '0;
            valid_q <= '0;
            fault_q <= '0;
        end else begin
            for (int p = 0; p < NUM_READ; p++) begin
                valid_q[p] <= bus.read_en[p];
                fault_q[p] <= bus.read_en[p] & rd_fault_c[p];
                if (bus.read_en[p]) begin
                    instr_q[p*BITWIDTH +: BITWIDTH] <= rd_fault_c[p] ? '0 : mem[AW'(rd_word[p])];
                end
            end
        end
    end

    assign bus.read_instr = instr_q;
    assign bus.read_valid = valid_q;
    assign bus.read_fault = fault_q;
    assign bus.load_busy  = (state_q == LOAD);
    assign bus.load_ready = (state_q == LOAD);
    assign bus.load_done  = done_q;
    assign bus.load_error = error_q;
endmodule

// File: tb/tb_imem_multiport.sv
// Scoreboard bench for imem_multiport: directed scenarios followed by random traffic.
module tb_imem_multiport;
    localparam int unsigned DEPTH    = 32;
    localparam int unsigned BW       = 32;
    localparam int unsigned NUM_READ = 2;

    typedef struct {
        int unsigned cyc;
        int unsigned port;
        logic        fault;
        logic [31:0] data;
    } rexp_t;

    typedef struct {
        int unsigned cyc;
        logic        is_done;
    } lexp_t;

    logic clock;
    logic reset;
    imem_multiport_if #(.BITWIDTH(BW), .NUM_READ(NUM_READ)) bus ();

    imem_multiport #(.DEPTH(DEPTH), .BITWIDTH(BW), .NUM_READ(NUM_READ)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned cyc = 0;
    logic        rst_seen = 1'b0;
    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    int    errors = 0;
    int    checks = 0;
    rexp_t rq[$];
    lexp_t lq[$];

    // Reference model: memory image plus the outstanding load, by spec rules
    logic [31:0] m_mem [DEPTH];
    bit          m_busy = 1'b0;
    int unsigned m_ptr  = 0;
    longint      m_rem  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic clr();
        reset          = 1'b0;
        bus.read_en    = '0;
        bus.read_addr  = '0;
        bus.load_start = 1'b0;
        bus.load_base  = '0;
        bus.load_count = '0;
        bus.load_data  = '0;
        bus.load_valid = 1'b0;
    endtask

    task automatic rd(input int p, input logic [31:0] a);
        bus.read_en[p]           = 1'b1;
        bus.read_addr[p*BW +: BW] = a;
    endtask

    task automatic start(input logic [31:0] base, input logic [31:0] count);
        bus.load_start = 1'b1;
        bus.load_base  = base;
        bus.load_count = count;
    endtask

    task automatic beat(input logic [31:0] d);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
    endtask

    // Predict the effect of the coming edge, then advance one cycle
    task automatic step();
        int unsigned c      = cyc + 1;
        bit          busy_n = m_busy;
        if (reset) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            busy_n = 1'b0;
            m_rem  = 0;
        end else begin
            for (int p = 0; p < NUM_READ; p++) begin
                if (bus.read_en[p]) begin
                    rexp_t       e;
                    logic [31:0] a;
                    a       = bus.read_addr[p*BW +: BW];
                    e.cyc   = c;
                    e.port  = p;
                    e.fault = (a % 4 != 0) || ((a / 4) >= DEPTH);
                    e.data  = e.fault ? 32'h0 : m_mem[a / 4];
                    rq.push_back(e);
                end
            end
            if (m_busy) begin
                if (bus.load_valid) begin
                    m_mem[m_ptr] = bus.load_data;
                    m_ptr++;
                    m_rem--;
                    if (m_rem == 0) begin
                        busy_n = 1'b0;
                        lq.push_back('{c, 1'b1});
                    end
                end
            end else if (bus.load_start) begin
                if ((bus.load_base % 4 != 0) ||
                    (64'(bus.load_base / 4) + 64'(bus.load_count) > 64'(DEPTH))) begin
                    lq.push_back('{c, 1'b0});
                end else if (bus.load_count == 0) begin
                    lq.push_back('{c, 1'b1});
                end else begin
                    busy_n = 1'b1;
                    m_ptr  = bus.load_base / 4;
                    m_rem  = longint'(bus.load_count);
                end
            end
        end
        @(posedge clock);
        #1;
        m_busy = busy_n;
    endtask

    // Monitor: compares every output each cycle against the queued expectations
    logic [31:0] last_instr [NUM_READ];
    initial foreach (last_instr[i]) last_instr[i] = '0;

    always @(negedge clock) begin
        if (cyc != 0) begin
            if (rst_seen) begin
                chk("reset_outputs",
                    {bus.read_instr, bus.read_valid, bus.read_fault,
                     bus.load_ready, bus.load_busy, bus.load_done, bus.load_error}, '0);
                foreach (last_instr[i]) last_instr[i] = '0;
            end else begin
                chk("load_busy", bus.load_busy, m_busy);
                chk("load_ready", bus.load_ready, m_busy);
                for (int p = 0; p < NUM_READ; p++) begin
                    if (rq.size() > 0 && rq[0].cyc == cyc && rq[0].port == p) begin
                        rexp_t e;
                        e = rq.pop_front();
                        chk($sformatf("read_valid%0d", p), bus.read_valid[p], 1'b1);
                        chk($sformatf("read_fault%0d", p), bus.read_fault[p], e.fault);
                        chk($sformatf("read_instr%0d", p), bus.read_instr[p*BW +: BW], e.data);
                        last_instr[p] = e.data;
                    end else begin
                        chk($sformatf("idle_valid_fault%0d", p),
                            {bus.read_valid[p], bus.read_fault[p]}, 2'b00);
                        chk($sformatf("hold_instr%0d", p), bus.read_instr[p*BW +: BW], last_instr[p]);
                    end
                end
                if (lq.size() > 0 && lq[0].cyc == cyc) begin
                    lexp_t e;
                    e = lq.pop_front();
                    chk("load_done_error", {bus.load_done, bus.load_error}, {e.is_done, ~e.is_done});
                end else begin
                    chk("no_done_error", {bus.load_done, bus.load_error}, 2'b00);
                end
            end
        end
    end

    initial begin
        foreach (m_mem[i]) m_mem[i] = '0;
        clr();
        reset = 1'b1;
        step();
        step();

        // reset then read
        clr(); rd(0, 32'h0); rd(1, 32'h4); step();

        // load with a stall, then readback
        clr(); start(32'h10, 32'd3); step();
        clr(); beat(32'hA1); step();
        clr(); step();
        clr(); beat(32'hA2); step();
        clr(); beat(32'hA3); step();
        clr(); rd(0, 32'h14); rd(1, 32'h18); step();

        // faults beside a clean read
        clr(); rd(0, 32'h2); rd(1, DEPTH * 4); step();
        clr(); rd(0, DEPTH * 4); rd(1, 32'h0); step();

        // rejected and boundary loads
        clr(); start(32'h3, 32'd1); step();
        clr(); start((DEPTH - 2) * 4, 32'd3); step();
        clr(); start((DEPTH - 2) * 4, 32'd2); step();
        clr(); beat(32'hC1); step();
        clr(); beat(32'hC2); step();
        clr(); rd(0, (DEPTH - 1) * 4); rd(1, 32'h14); step();
        clr(); start(32'h0, 32'd0); step();

        // collision and ignored start
        clr(); start(32'h20, 32'd3); step();
        clr(); beat(32'hB1); rd(0, 32'h20); step();
        clr(); beat(32'hB2); start(32'h0, 32'd5); rd(1, 32'h24); step();
        clr(); beat(32'hB3); step();
        clr(); rd(0, 32'h20); rd(1, 32'h24); step();
        clr(); rd(0, 32'h28); rd(1, 32'h2C); step();

        // reset mid-load
        clr(); start(32'h40, 32'd4); step();
        clr(); beat(32'hD1); step();
        clr(); reset = 1'b1; step();
        clr(); rd(0, 32'h40); step();
        clr(); beat(32'hD2); step();
        clr(); step();

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            clr();
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
            end else begin
                for (int p = 0; p < NUM_READ; p++) begin
                    if ($urandom_range(0, 2) != 0) begin
                        int unsigned k;
                        logic [31:0] a;
                        k = $urandom_range(0, 9);
                        if (k < 7)       a = $urandom_range(0, DEPTH - 1) * 4;
                        else if (k == 7) a = $urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3);
                        else if (k == 8) a = $urandom;
                        else             a = (DEPTH - 1 + $urandom_range(0, 1)) * 4;
                        rd(p, a);
                    end
                end
                if ($urandom_range(0, m_busy ? 19 : 5) == 0) begin
                    int unsigned k;
                    logic [31:0] base;
                    logic [31:0] count;
                    k     = $urandom_range(0, 9);
                    base  = $urandom_range(0, DEPTH - 1) * 4;
                    count = $urandom_range(0, 6);
                    if (k == 0) base = base + $urandom_range(1, 3);
                    if (k == 1) count = 32'hFFFF_FFFF;
                    if (k == 2) base = $urandom;
                    start(base, count);
                end
                if ($urandom_range(0, 9) < 6) beat($urandom);
            end
            step();
        end

        // drain outstanding load and reads
        clr();
        for (int n = 0; n < 20 && m_busy; n++) begin
            clr(); beat($urandom); step();
        end
        clr(); step();
        step();
        chk("drain_read_queue", rq.size(), 0);
        chk("drain_load_queue", lq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
